// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   owner_t          : which requester a pending read response belongs to
//   prio_t           : arbitration priority state (CPU by default, DMA after starvation)
//   STARVE_LIMIT_DEF : default count of denied DMA cycles before DMA gets priority
//   CNT_W            : width of the starvation counter
package dmem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   typedef enum logic {
      CPU_PRIO = 1'b0,
      DMA_PRIO = 1'b1
   } prio_t;

   localparam int unsigned STARVE_LIMIT_DEF = 4;
   localparam int unsigned CNT_W            = 4;

endpackage

// File: rtl/dmem_prio_fsm.sv
// Starvation counter and priority state machine for the data-memory arbiter.
//   clk, reset  : clock, asynchronous active-high reset
//   dma_req     : DMA is requesting this cycle
//   dma_gnt     : DMA was granted this cycle (from the arbiter's grant logic)
//   prio_state  : registered priority state (CPU_PRIO / DMA_PRIO)
//   starve_cnt  : registered count of consecutive denied DMA cycles (saturates at 15)
module dmem_prio_fsm
   import dmem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dma_req,
   input  logic             dma_gnt,
   output prio_t            prio_state,
   output logic [CNT_W-1:0] starve_cnt
);

   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   prio_t            state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CPU_PRIO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      cnt_d   = '0;
      state_d = state_q;

      if (dma_req && !dma_gnt) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end

      // Switch on the updated count so DMA wins in the cycle right after
      // the STARVE_LIMIT-th denial.
      case (state_q)
         CPU_PRIO: if (cnt_d >= LIMIT) state_d = DMA_PRIO;
         DMA_PRIO: if (dma_gnt)        state_d = CPU_PRIO;
         default:                      state_d = CPU_PRIO;
      endcase
   end

   assign prio_state = state_q;
   assign starve_cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU MEM stage and DMA/loader) for a single-port
// data memory with one-cycle read latency.
//   clk, reset                         : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata              : CPU access request
//   cpu_stall                          : CPU request pending but not granted
//   cpu_rvalid/rdata                   : CPU load response (one cycle after grant)
//   dma_req/we/addr/wdata              : DMA access request
//   dma_gnt                            : DMA request accepted this cycle
//   dma_rvalid/rdata                   : DMA read response (one cycle after grant)
//   mem_address/write_data/write_mask  : memory port, driven by the granted requester
//   mem_memwrite/memread               : memory strobes, low when nothing is granted
//   mem_read_data                      : memory read data, one cycle after memread
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,

   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,

   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_write_mask,
   output logic        mem_memwrite,
   output logic        mem_memread,
   input  logic [31:0] mem_read_data
);

   prio_t            prio_state;
   logic [CNT_W-1:0] starve_cnt;
   logic             cpu_gnt;
   owner_t           owner_q, owner_d;

   dmem_prio_fsm #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clk        (clk),
      .reset      (reset),
      .dma_req    (dma_req),
      .dma_gnt    (dma_gnt),
      .prio_state (prio_state),
      .starve_cnt (starve_cnt)
   );

   always_comb begin
      dma_gnt        = dma_req && (!cpu_req || (prio_state == DMA_PRIO));
      cpu_gnt        = cpu_req && !dma_gnt;
      cpu_stall      = cpu_req && !cpu_gnt;

      mem_address    = '0;
      mem_write_data = '0;
      mem_write_mask = '0;
      mem_memwrite   = 1'b0;
      mem_memread    = 1'b0;
      owner_d        = OWN_NONE;

      if (cpu_gnt) begin
         mem_address    = cpu_addr;
         mem_write_data = cpu_wdata;
         mem_write_mask = cpu_we ? 4'b1111 : 4'b0000;
         mem_memwrite   = cpu_we;
         mem_memread    = !cpu_we;
         owner_d        = cpu_we ? OWN_NONE : OWN_CPU;
      end else if (dma_gnt) begin
         mem_address    = dma_addr;
         mem_write_data = dma_wdata;
         mem_write_mask = dma_we ? 4'b1111 : 4'b0000;
         mem_memwrite   = dma_we;
         mem_memread    = !dma_we;
         owner_d        = dma_we ? OWN_NONE : OWN_DMA;
      end
   end

   // Async reset of the owner drops any in-flight response immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) owner_q <= OWN_NONE;
      else       owner_q <= owner_d;
   end

   always_comb begin
      cpu_rvalid = (owner_q == OWN_CPU);
      dma_rvalid = (owner_q == OWN_DMA);
      cpu_rdata  = cpu_rvalid ? mem_read_data : '0;
      dma_rdata  = dma_rvalid ? mem_read_data : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// one-cycle-latency memory (fixed contents, reads only).
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = '0, dma_wdata = '0;
   logic        dma_gnt, dma_rvalid;
   logic [31:0] dma_rdata;
   logic [31:0] mem_address, mem_write_data;
   logic [3:0]  mem_write_mask;
   logic        mem_memwrite, mem_memread;
   logic [31:0] mem_read_data = '0;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   dmem_arbiter #(
      .STARVE_LIMIT (4)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_stall      (cpu_stall),
      .cpu_rvalid     (cpu_rvalid),
      .cpu_rdata      (cpu_rdata),
      .dma_req        (dma_req),
      .dma_we         (dma_we),
      .dma_addr       (dma_addr),
      .dma_wdata      (dma_wdata),
      .dma_gnt        (dma_gnt),
      .dma_rvalid     (dma_rvalid),
      .dma_rdata      (dma_rdata),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_write_mask (mem_write_mask),
      .mem_memwrite   (mem_memwrite),
      .mem_memread    (mem_memread),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   // Memory contents: 0x10 holds 0xDEADBEEF, every other word is 0xA5000000 | addr.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : (32'hA5000000 | a);
   endfunction

   always @(posedge clk) begin
      if (mem_memread) mem_read_data <= mem_word(mem_address);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_addr;

      // Reset state (reset held from time 0)
      #2;
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
      check("rst_cnt", 32'(u_dut.u_prio.starve_cnt), 32'd0);
      check("rst_prio", 32'(u_dut.u_prio.prio_state), 32'(CPU_PRIO));
      tick();
      tick();
      reset = 1'b0;
      tick();

      // CPU-only load
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      #1;
      check("ld_memread", 32'(mem_memread), 32'd1);
      check("ld_addr", mem_address, 32'h10);
      check("ld_stall", 32'(cpu_stall), 32'd0);
      check("ld_memwrite", 32'(mem_memwrite), 32'd0);
      tick();
      cpu_req = 1'b0;
      #1;
      check("ld_rvalid", 32'(cpu_rvalid), 32'd1);
      check("ld_rdata", cpu_rdata, 32'hDEADBEEF);
      check("ld_dma_rvalid", 32'(dma_rvalid), 32'd0);
      tick();
      #1;
      check("ld_rvalid_drop", 32'(cpu_rvalid), 32'd0);
      check("ld_rdata_zero", cpu_rdata, 32'd0);

      // Starvation: both request for 6 cycles, DMA wins on cycle 4
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h34;
      for (int i = 0; i < 6; i++) begin
         #1;
         exp_addr = (i == 4) ? 32'h34 : 32'h30;
         check($sformatf("stv_gnt%0d", i), 32'(dma_gnt), (i == 4) ? 32'd1 : 32'd0);
         check($sformatf("stv_stall%0d", i), 32'(cpu_stall), (i == 4) ? 32'd1 : 32'd0);
         check($sformatf("stv_addr%0d", i), mem_address, exp_addr);
         check($sformatf("stv_cnt%0d", i), 32'(u_dut.u_prio.starve_cnt), (i == 5) ? 32'd0 : 32'(i));
         if (i > 0) begin
            check($sformatf("stv_crv%0d", i), 32'(cpu_rvalid), (i == 5) ? 32'd0 : 32'd1);
            check($sformatf("stv_drv%0d", i), 32'(dma_rvalid), (i == 5) ? 32'd1 : 32'd0);
            check($sformatf("stv_rd%0d", i), (i == 5) ? dma_rdata : cpu_rdata,
                  (i == 5) ? 32'hA5000034 : 32'hA5000030);
         end
         tick();
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      tick();
      tick();

      // Alternating owners without a bubble
      cpu_req = 1'b1; cpu_addr = 32'h20;
      #1;
      check("alt_addr0", mem_address, 32'h20);
      tick();
      cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h24;
      #1;
      check("alt_dgnt1", 32'(dma_gnt), 32'd1);
      check("alt_crv1", 32'(cpu_rvalid), 32'd1);
      check("alt_crd1", cpu_rdata, 32'hA5000020);
      check("alt_drv1", 32'(dma_rvalid), 32'd0);
      tick();
      dma_req = 1'b0;
      #1;
      check("alt_drv2", 32'(dma_rvalid), 32'd1);
      check("alt_drd2", dma_rdata, 32'hA5000024);
      check("alt_crv2", 32'(cpu_rvalid), 32'd0);
      check("alt_crd2", cpu_rdata, 32'd0);
      tick();
      #1;
      check("alt_drv3", 32'(dma_rvalid), 32'd0);
      check("alt_drd3", dma_rdata, 32'd0);

      // DMA write with CPU idle
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
      #1;
      check("wr_gnt", 32'(dma_gnt), 32'd1);
      check("wr_memwrite", 32'(mem_memwrite), 32'd1);
      check("wr_memread", 32'(mem_memread), 32'd0);
      check("wr_mask", 32'(mem_write_mask), 32'hF);
      check("wr_addr", mem_address, 32'h40);
      check("wr_data", mem_write_data, 32'h12345678);
      tick();
      dma_req = 1'b0; dma_we = 1'b0;
      #1;
      check("wr_no_rvalid", 32'(dma_rvalid), 32'd0);
      check("wr_rdata_zero", dma_rdata, 32'd0);
      check("wr_idle_mask", 32'(mem_write_mask), 32'd0);

      // Reset mid-read, with the starve counter non-zero
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      dma_req = 1'b1; dma_addr = 32'h34;
      tick();
      tick();
      #1;
      check("mr_cnt_pre", 32'(u_dut.u_prio.starve_cnt), 32'd2);
      check("mr_memread", 32'(mem_memread), 32'd1);
      check("mr_cpu_gnt_addr", mem_address, 32'h10);
      #2;
      reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
      #1;
      check("mr_cnt_async", 32'(u_dut.u_prio.starve_cnt), 32'd0);
      check("mr_rvalid_async", 32'(cpu_rvalid), 32'd0);
      tick();
      check("mr_rvalid_held", 32'(cpu_rvalid), 32'd0);
      reset = 1'b0;
      tick();
      check("mr_rvalid_after", 32'(cpu_rvalid), 32'd0);
      check("mr_drvalid_after", 32'(dma_rvalid), 32'd0);
      check("mr_cnt_after", 32'(u_dut.u_prio.starve_cnt), 32'd0);
      check("mr_prio_after", 32'(u_dut.u_prio.prio_state), 32'(CPU_PRIO));

      // Idle
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("idle_rd%0d", i), 32'(mem_memread), 32'd0);
         check($sformatf("idle_wr%0d", i), 32'(mem_memwrite), 32'd0);
         check($sformatf("idle_rv%0d", i), 32'({cpu_rvalid, dma_rvalid}), 32'd0);
         check($sformatf("idle_cnt%0d", i), 32'(u_dut.u_prio.starve_cnt), 32'd0);
         check($sformatf("idle_gnt%0d", i), 32'({cpu_stall, dma_gnt}), 32'd0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
